// File: rtl/mops_sdo_pkg.sv
// Shared types and constants for the MOPS SDO responder: FSM states,
// SDO command specifiers, abort codes and the emulated ADC object location.
package mops_sdo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } sdo_state_e;

  localparam int FRAME_W = 76;

  localparam logic [7:0]  SDO_CMD_UPLOAD_REQ = 8'h40;
  localparam logic [7:0]  SDO_CMD_UPLOAD_RSP = 8'h43;
  localparam logic [7:0]  SDO_CMD_ABORT      = 8'h80;

  localparam logic [31:0] ABORT_NO_OBJECT    = 32'h0602_0000;
  localparam logic [31:0] ABORT_BAD_CMD      = 32'h0504_0001;

  localparam logic [10:0] COB_RSDO_BASE      = 11'h600;
  localparam logic [10:0] COB_TSDO_BASE      = 11'h580;

  localparam logic [15:0] ADC_INDEX          = 16'h2400;
  localparam logic [7:0]  ADC_SUB_MAX        = 8'd35;

  // CANopen carries multi-byte values little-endian: byte4 holds the LSB.
  function automatic logic [31:0] to_le32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/mops_sdo_decode.sv
// Combinational SDO request decoder: turns the request header (COB-ID, RTR,
// payload bytes 0..3) plus the current ADC base into a complete uplink frame.
// Request bytes 4..7 carry nothing for an upload request, so only the header
// is brought in.
module mops_sdo_decode
  import mops_sdo_pkg::*;
#(
  parameter logic [6:0] NODE_ID = 7'd0
) (
  input  logic [43:0] req_head,
  input  logic [11:0] adc_base,
  output logic [75:0] rsp_frame,
  output logic        drop
);

  logic [10:0] cob;
  logic        rtr;
  logic [7:0]  b0, b1, b2, b3;
  logic [11:0] adc_val;
  logic [31:0] tail;
  logic [7:0]  cmd;

  // Classify the request and assemble the response payload.
  always_comb begin
    cob     = req_head[43:33];
    rtr     = req_head[32];
    b0      = req_head[31:24];
    b1      = req_head[23:16];
    b2      = req_head[15:8];
    b3      = req_head[7:0];
    adc_val = adc_base + {4'h0, b3};
    drop    = (cob != (COB_RSDO_BASE + {4'h0, NODE_ID})) || rtr;
    cmd     = SDO_CMD_ABORT;
    tail    = to_le32(ABORT_BAD_CMD);
    if (b0 == SDO_CMD_UPLOAD_REQ) begin
      if (({b2, b1} == ADC_INDEX) && (b3 != 8'd0) && (b3 <= ADC_SUB_MAX)) begin
        cmd  = SDO_CMD_UPLOAD_RSP;
        tail = {adc_val[7:0], 4'h0, adc_val[11:8], 16'h0000};
      end else begin
        tail = to_le32(ABORT_NO_OBJECT);
      end
    end
    rsp_frame = {COB_TSDO_BASE + {4'h0, NODE_ID}, 1'b0, cmd, b1, b2, b3, tail};
  end

endmodule

// File: rtl/mops_sdo_responder.sv
// MOPS SDO responder: accepts one downlink SDO request at a time, answers
// uploads of the emulated ADC object after a fixed delay, and holds the
// response until the consumer takes it.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   DECODE | request registered, response built or request dropped
//   WAIT   | delay counter running down to zero
//   RESP   | rsp_valid high until rsp_ready
module mops_sdo_responder
  import mops_sdo_pkg::*;
#(
  parameter logic [6:0] NODE_ID    = 7'd0,
  parameter int         RESP_DELAY = 8
) (
  input  logic        clk_40_m,
  input  logic        rst,
  input  logic [75:0] req_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] adc_base,
  output logic [75:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_cnt,
  output logic [7:0]  drop_cnt
);

  // DECODE consumes one cycle of the delay and the RESP transition another.
  localparam logic [7:0] DLY_LOAD = 8'(RESP_DELAY - 2);

  sdo_state_e  state_q, state_d;
  logic [43:0] req_head_q, req_head_d;
  logic [7:0]  dly_q, dly_d;
  logic [75:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        req_ready_q, req_ready_d;
  logic [15:0] rsp_cnt_q, rsp_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic [75:0] dec_frame;
  logic        dec_drop;

  mops_sdo_decode #(.NODE_ID(NODE_ID)) u_decode (
    .req_head (req_head_q),
    .adc_base (adc_base),
    .rsp_frame(dec_frame),
    .drop     (dec_drop)
  );

  // Next-state and next-output logic for the request/response sequence.
  always_comb begin
    state_d     = state_q;
    req_head_d  = req_head_q;
    dly_d       = dly_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_cnt_d   = rsp_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_head_d = req_data[75:32];
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_drop) begin
          if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
          state_d = ST_IDLE;
        end else begin
          rsp_data_d = dec_frame;
          dly_d      = DLY_LOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dly_q == 8'd0) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_cnt_d   = rsp_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // Register all state; synchronous active-low reset discards any transaction.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_head_q  <= '0;
      dly_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_head_q  <= req_head_d;
      dly_q       <= dly_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      rsp_cnt_q   <= rsp_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_cnt   = rsp_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/mops_sdo_responder.md
MOPS_SDO_RESPONDER -- requirements
Module: mops_sdo_responder

Interface
REQ-001 Parameter NODE_ID, default 7'd0: CANopen node ID this responder answers for.
REQ-002 Parameter RESP_DELAY, default 8: cycles from request accept to rsp_valid; legal range 2..255.
REQ-003 clk_40_m  input  1: sole clock; all logic on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-low.
REQ-005 req_data  input  76: downlink frame; [75:65] COB-ID, [64] RTR, [63:0] payload, byte0 at [63:56].
REQ-006 req_valid  input  1: req_data valid.
REQ-007 req_ready  output  1: responder can accept a request.
REQ-008 adc_base  input  12: emulated ADC base value.
REQ-009 rsp_data  output  76: uplink frame, same layout as req_data.
REQ-010 rsp_valid  output  1: rsp_data valid.
REQ-011 rsp_ready  input  1: consumer accepts rsp_data.
REQ-012 rsp_cnt  output  16: responses delivered, wraps at 0xFFFF->0.
REQ-013 drop_cnt  output  8: requests ignored, saturates at 0xFF.

Function
REQ-014 FSM states are IDLE, DECODE, WAIT, RESP; reset state is IDLE.
REQ-015 req_ready is 1 only in IDLE; a request is accepted when req_valid && req_ready, and req_data is registered the same edge.
REQ-016 IDLE->DECODE on accept; otherwise stay in IDLE.
REQ-017 In DECODE, a COB-ID other than 0x600+NODE_ID, or RTR=1, returns to IDLE, increments drop_cnt (saturating) and produces no response.
REQ-018 In DECODE, a valid request builds the response and moves to WAIT; the delay counter loads RESP_DELAY-2.
REQ-019 WAIT decrements the counter; at 0 go to RESP, so rsp_valid rises exactly RESP_DELAY cycles after the accept edge.
REQ-020 RESP holds rsp_valid=1 and rsp_data stable until rsp_ready=1; on that edge rsp_cnt increments and the FSM goes to IDLE.
REQ-021 The response COB-ID is 0x580+NODE_ID, RTR=0.
REQ-022 Upload response: when byte0=0x40, index {byte2,byte1}=0x2400 and subindex byte3 in 1..35, send byte0=0x43, bytes1-3 echoed, {byte5,byte4}={4'h0, adc_base+subindex mod 4096}, bytes6-7=0.
REQ-023 Unknown object: when byte0=0x40 and the index/subindex is not valid, send byte0=0x80, bytes1-3 echoed, bytes4-7 = abort code 0x06020000 little-endian (byte7=0x06).
REQ-024 Bad command: when byte0 != 0x40, send byte0=0x80, bytes1-3 echoed, abort code 0x05040001.
REQ-025 adc_base is sampled in DECODE; later changes do not alter a pending response.
REQ-026 rsp_ready while rsp_valid=0 is ignored.
REQ-027 req_valid while busy is not accepted; the upstream holds it, and no request is lost or duplicated.
REQ-028 Back-to-back traffic: a request presented in the cycle after rsp handshake is accepted in that cycle (IDLE).

Reset
REQ-029 With rst=0 at a clock edge: state=IDLE, rsp_valid=0, rsp_data=0, req_ready=0, rsp_cnt=0, drop_cnt=0, delay counter=0.
REQ-030 req_ready goes to 1 on the first edge after rst returns to 1.
REQ-031 Reset mid-transaction (DECODE/WAIT/RESP) discards the transaction; no response follows after rst is released.

Structure
REQ-032 Package mops_sdo_pkg holds the FSM state enum, SDO command constants (0x40, 0x43, 0x80), abort codes, COB-ID bases 0x600/0x580, index 0x2400 and max subindex 35.
REQ-033 One sub-module, mops_sdo_decode: combinational, request frame + adc_base -> response frame + drop flag; the FSM/counters stay in the top.

Verification
REQ-034 NODE_ID=0, adc_base=0x100, request COB 0x600 payload 40 00 24 05 00.. -> after exactly 8 cycles, rsp COB 0x580, payload 43 00 24 05 05 01 00 00; rsp_cnt=1.
REQ-035 Request with subindex 0x30 -> abort 80 00 24 30 00 00 02 06; request with byte0=0x22 -> abort 80 .. 01 00 04 05.
REQ-036 COB 0x601 to NODE_ID=0 -> no rsp_valid within 20 cycles; drop_cnt=1; 300 such requests -> drop_cnt=0xFF.
REQ-037 Hold rsp_ready=0 for 50 cycles -> rsp_valid and rsp_data stable and req_ready=0; then a second request held during that time is accepted right after the handshake.
REQ-038 Assert rst=0 during WAIT -> all outputs reach their reset values next edge; no response after release.
REQ-039 adc_base=0xFFF, subindex 35 -> data bytes 22 00 (wrap mod 4096).
